// File: rtl/dcache_pkg.sv
// dcache_pkg
//   Shared definitions for the data-cache controller:
//   - state_t      : 2-bit controller state encoding
//   - idx_width()  : index width derived from the line count
//   - tag_width()  : tag width derived from address width and line count
//   - CNT_MAX      : saturation value of the hit/miss counters
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DRAIN     = 2'd1,
    FILL_REQ  = 2'd2,
    FILL_WAIT = 2'd3
  } state_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  function automatic int idx_width(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_width(input int addr_w, input int lines);
    return addr_w - $clog2(lines);
  endfunction

endpackage

// File: rtl/dcache_wbuf.sv
// dcache_wbuf
//   Single-entry write buffer plus the backing-memory request mux.
//   While the buffer holds a store it owns the memory port (write request);
//   otherwise a fill request from the controller is forwarded.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   load                  capture load_addr/load_data into the buffer
//   fill_req, fill_addr   controller wants a read fill at fill_addr
//   mem_req_ready         memory accepts the current request
//   full                  buffer holds an undrained store
//   drain_done            buffered store is handed off this cycle
//   mem_req_*             request outputs toward backing memory
module dcache_wbuf #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              fill_req,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic              mem_req_ready,
  output logic              full,
  output logic              drain_done,
  output logic              mem_req_valid,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata
);

  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic              full_reg;

  assign full       = full_reg;
  assign drain_done = full_reg & mem_req_ready;

  // A load in the same cycle as a drain refills the entry, so the port
  // sees back-to-back write transactions with no idle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg <= 1'b0;
      addr_reg <= '0;
      data_reg <= '0;
    end else if (load) begin
      full_reg <= 1'b1;
      addr_reg <= load_addr;
      data_reg <= load_data;
    end else if (drain_done) begin
      full_reg <= 1'b0;
    end
  end

  // Drain wins the port; unused request fields are driven to zero.
  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    if (full_reg) begin
      mem_req_valid = 1'b1;
      mem_req_we    = 1'b1;
      mem_req_addr  = addr_reg;
      mem_req_wdata = data_reg;
    end else if (fill_req) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = fill_addr;
    end
  end

endmodule

// File: rtl/d_cache_ctrl.sv
// d_cache_ctrl
//   Direct-mapped, write-through, no-write-allocate data cache for the MEM
//   stage. One word per line, single-entry write buffer, valid/ready port to
//   backing memory.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   rd_en, rd_dest                  load request / address
//   wr_en, wr_dest, wr_data         store request / address / data
//   rd_out, rd_valid                registered load data and its 1-cycle strobe
//   stall                           combinational hold request to the pipeline
//   mem_req_valid/ready/we/addr/wdata  backing-memory request channel
//   mem_resp_valid, mem_resp_data   backing-memory read response
//   hit_count, miss_count           saturating read hit/miss counters
module d_cache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_dest,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] wr_dest,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic [DATA_W-1:0] rd_out,
  output logic              rd_valid,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int IDX_W = idx_width(LINES);
  localparam int TAG_W = tag_width(ADDR_W, LINES);

  state_t state_reg, state_next;

  logic [LINES-1:0]  valid_reg;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             rd_hit, wr_hit;

  logic wbuf_full, wbuf_drain_done;
  logic wr_accept, rd_hit_go, rd_miss_go, fill_req, fill_done;

  assign rd_idx = rd_dest[IDX_W-1:0];
  assign rd_tag = rd_dest[ADDR_W-1:IDX_W];
  assign wr_idx = wr_dest[IDX_W-1:0];
  assign wr_tag = wr_dest[ADDR_W-1:IDX_W];
  assign rd_hit = valid_reg[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign wr_hit = valid_reg[wr_idx] && (tag_mem[wr_idx] == wr_tag);

  dcache_wbuf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_wbuf (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (wr_accept),
    .load_addr    (wr_dest),
    .load_data    (wr_data),
    .fill_req     (fill_req),
    .fill_addr    (rd_dest),
    .mem_req_ready(mem_req_ready),
    .full         (wbuf_full),
    .drain_done   (wbuf_drain_done),
    .mem_req_valid(mem_req_valid),
    .mem_req_we   (mem_req_we),
    .mem_req_addr (mem_req_addr),
    .mem_req_wdata(mem_req_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // A simultaneous load and store is treated as the store alone. The fill
  // address comes straight from rd_dest, which the pipeline holds during stall.
  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    wr_accept  = 1'b0;
    rd_hit_go  = 1'b0;
    rd_miss_go = 1'b0;
    fill_req   = 1'b0;
    fill_done  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (wr_en) begin
          // Entry frees up this cycle if the buffered store is handed off.
          if (!wbuf_full || wbuf_drain_done) wr_accept = 1'b1;
          else                               stall     = 1'b1;
        end else if (rd_en) begin
          if (rd_hit) begin
            rd_hit_go = 1'b1;
          end else begin
            rd_miss_go = 1'b1;
            stall      = 1'b1;
            state_next = wbuf_full ? DRAIN : FILL_REQ;
          end
        end
      end
      DRAIN: begin
        // Older store must reach memory before the fill reads it back.
        stall = 1'b1;
        if (!wbuf_full || wbuf_drain_done) state_next = FILL_REQ;
      end
      FILL_REQ: begin
        stall    = 1'b1;
        fill_req = 1'b1;
        if (mem_req_ready) state_next = FILL_WAIT;
      end
      FILL_WAIT: begin
        stall = ~mem_resp_valid;
        if (mem_resp_valid) begin
          fill_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg  <= '0;
      rd_out     <= '0;
      rd_valid   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (rd_hit_go) begin
        rd_out   <= data_mem[rd_idx];
        rd_valid <= 1'b1;
        if (hit_count != CNT_MAX) hit_count <= hit_count + 16'd1;
      end
      if (rd_miss_go && (miss_count != CNT_MAX)) miss_count <= miss_count + 16'd1;
      if (fill_done) begin
        rd_out            <= mem_resp_data;
        rd_valid          <= 1'b1;
        valid_reg[rd_idx] <= 1'b1;
      end
    end
  end

  // Tag/data storage needs no reset: valid_reg gates every lookup.
  // Fills (FILL_WAIT) and stores (IDLE) can never coincide.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[rd_idx]  <= rd_tag;
      data_mem[rd_idx] <= mem_resp_data;
    end else if (wr_accept && wr_hit) begin
      data_mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_d_cache_ctrl.sv
module tb_d_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] rd_dest, wr_dest, wr_data;
  logic        rd_en, wr_en;
  logic [15:0] rd_out;
  logic        rd_valid, stall;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [15:0] mem_req_addr, mem_req_wdata;
  logic        mem_resp_valid;
  logic [15:0] mem_resp_data;
  logic [15:0] hit_count, miss_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  d_cache_ctrl #(.LINES(16), .ADDR_W(16), .DATA_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_dest       (rd_dest),
    .rd_en         (rd_en),
    .wr_dest       (wr_dest),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .rd_out        (rd_out),
    .rd_valid      (rd_valid),
    .stall         (stall),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .hit_count     (hit_count),
    .miss_count    (miss_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Read miss with empty write buffer: request, handshake, respond after 3 cycles.
  task automatic fill_miss(input logic [15:0] addr, input logic [15:0] data,
                           input logic [15:0] exp_miss);
    rd_dest = addr;
    rd_en   = 1'b1;
    settle();
    chk("miss_stall", {15'd0, stall}, 16'd1);
    tick();
    chk("fill_valid", {15'd0, mem_req_valid}, 16'd1);
    chk("fill_we", {15'd0, mem_req_we}, 16'd0);
    chk("fill_addr", mem_req_addr, addr);
    chk("miss_count", miss_count, exp_miss);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    settle();
    chk("wait_no_req", {15'd0, mem_req_valid}, 16'd0);
    chk("wait_stall", {15'd0, stall}, 16'd1);
    tick();
    tick();
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    settle();
    chk("resp_stall", {15'd0, stall}, 16'd0);
    tick();
    mem_resp_valid = 1'b0;
    rd_en          = 1'b0;
    chk("fill_rd_valid", {15'd0, rd_valid}, 16'd1);
    chk("fill_rd_out", rd_out, data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    rd_dest        = '0;
    wr_dest        = '0;
    wr_data        = '0;
    rd_en          = 1'b0;
    wr_en          = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    #12;
    chk("rst_rd_out", rd_out, 16'd0);
    chk("rst_rd_valid", {15'd0, rd_valid}, 16'd0);
    chk("rst_req_valid", {15'd0, mem_req_valid}, 16'd0);
    chk("rst_req_addr", mem_req_addr, 16'd0);
    chk("rst_req_wdata", mem_req_wdata, 16'd0);
    chk("rst_hits", hit_count, 16'd0);
    chk("rst_misses", miss_count, 16'd0);
    rst_n = 1'b1;
    tick();

    // Cold read of 0x0013
    fill_miss(16'h0013, 16'hBEEF, 16'd1);
    tick();
    chk("pulse_one_cycle", {15'd0, rd_valid}, 16'd0);
    chk("rd_out_hold", rd_out, 16'hBEEF);

    // Re-read is a hit
    rd_dest = 16'h0013;
    rd_en   = 1'b1;
    settle();
    chk("hit_stall", {15'd0, stall}, 16'd0);
    chk("hit_no_req", {15'd0, mem_req_valid}, 16'd0);
    tick();
    rd_en = 1'b0;
    chk("hit_rd_valid", {15'd0, rd_valid}, 16'd1);
    chk("hit_rd_out", rd_out, 16'hBEEF);
    chk("hit_count1", hit_count, 16'd1);

    // Write hit 0x0013 = 0x1234, then read it back while the write is pending
    wr_dest = 16'h0013;
    wr_data = 16'h1234;
    wr_en   = 1'b1;
    settle();
    chk("wr_stall", {15'd0, stall}, 16'd0);
    tick();
    wr_en = 1'b0;
    chk("wr_no_pulse", {15'd0, rd_valid}, 16'd0);
    settle();
    chk("wb_valid", {15'd0, mem_req_valid}, 16'd1);
    chk("wb_we", {15'd0, mem_req_we}, 16'd1);
    chk("wb_addr", mem_req_addr, 16'h0013);
    chk("wb_wdata", mem_req_wdata, 16'h1234);
    rd_en = 1'b1;
    settle();
    chk("rdw_stall", {15'd0, stall}, 16'd0);
    tick();
    rd_en = 1'b0;
    chk("rdw_rd_out", rd_out, 16'h1234);
    chk("rdw_rd_valid", {15'd0, rd_valid}, 16'd1);
    chk("hit_count2", hit_count, 16'd2);
    chk("wb_held", {15'd0, mem_req_valid}, 16'd1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    settle();
    chk("wb_drained", {15'd0, mem_req_valid}, 16'd0);

    // Conflict misses on index 3
    fill_miss(16'h0023, 16'h5555, 16'd2);
    fill_miss(16'h0013, 16'h1234, 16'd3);

    // Store miss with memory not ready, then read miss to 0x0040
    wr_dest = 16'h0050;
    wr_data = 16'hAAAA;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
    rd_dest = 16'h0040;
    rd_en   = 1'b1;
    settle();
    chk("drn_stall0", {15'd0, stall}, 16'd1);
    chk("drn_we0", {15'd0, mem_req_we}, 16'd1);
    chk("drn_addr0", mem_req_addr, 16'h0050);
    tick();
    chk("drn_miss_count", miss_count, 16'd4);
    chk("drn_stall1", {15'd0, stall}, 16'd1);
    chk("drn_we1", {15'd0, mem_req_we}, 16'd1);
    tick();
    chk("drn_addr_stable", mem_req_addr, 16'h0050);
    chk("drn_wdata_stable", mem_req_wdata, 16'hAAAA);
    mem_req_ready = 1'b1;
    tick();
    chk("after_drn_valid", {15'd0, mem_req_valid}, 16'd1);
    chk("after_drn_we", {15'd0, mem_req_we}, 16'd0);
    chk("after_drn_addr", mem_req_addr, 16'h0040);
    chk("after_drn_stall", {15'd0, stall}, 16'd1);
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 16'h0F0F;
    tick();
    mem_resp_valid = 1'b0;
    rd_en          = 1'b0;
    chk("drn_fill_out", rd_out, 16'h0F0F);
    chk("drn_fill_valid", {15'd0, rd_valid}, 16'd1);

    // Simultaneous load and store: only the store takes effect
    wr_dest       = 16'h0040;
    wr_data       = 16'h1111;
    wr_en         = 1'b1;
    rd_en         = 1'b1;
    mem_req_ready = 1'b1;
    settle();
    chk("both_stall", {15'd0, stall}, 16'd0);
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("both_no_pulse", {15'd0, rd_valid}, 16'd0);
    chk("both_no_hit", hit_count, 16'd2);
    chk("both_wb_wdata", mem_req_wdata, 16'h1111);
    tick();
    mem_req_ready = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("wr_hit_update", rd_out, 16'h1111);
    chk("hit_count3", hit_count, 16'd3);

    // Reset during FILL_WAIT
    rd_dest = 16'h0060;
    rd_en   = 1'b1;
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rd_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rd_out", rd_out, 16'd0);
    chk("arst_req_valid", {15'd0, mem_req_valid}, 16'd0);
    chk("arst_stall", {15'd0, stall}, 16'd0);
    chk("arst_hits", hit_count, 16'd0);
    chk("arst_misses", miss_count, 16'd0);
    tick();
    rst_n          = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 16'h7777;
    tick();
    mem_resp_valid = 1'b0;
    chk("stray_rd_valid", {15'd0, rd_valid}, 16'd0);
    chk("stray_rd_out", rd_out, 16'd0);
    chk("stray_req", {15'd0, mem_req_valid}, 16'd0);
    rd_en = 1'b1;
    settle();
    chk("post_rst_stall", {15'd0, stall}, 16'd1);
    tick();
    rd_en = 1'b0;
    chk("post_rst_miss", miss_count, 16'd1);
    chk("post_rst_hit", hit_count, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
